register_file_mp: RTL
=====================

// Module: register_file_mp
// PURPOSE
//  Multi-port general-purpose register file for the datapath; successor to the single-write, two-read file.
//  Provides READ_PORTS combinational read ports, two prioritised write ports and optional write-to-read bypass.
//  A sequenced bulk-clear engine zeroes the whole file, one register per cycle, under a start/busy/done handshake.
//  Sits between decode (reads) and writeback (writes); the clear engine is driven by the control unit.
// PARAMETERS
//  WORD_LEN    32  data width in bits
//  WORD_COUNT  15  number of registers; address width AW = $clog2(WORD_COUNT)
//  READ_PORTS  3   number of independent read ports
//  BYPASS      1   1: a read returns same-cycle write data; 0: a read returns stored contents only
//  RESET_MODE  1   reset value of register i: 1 = i (zero-extended to WORD_LEN), 0 = 0
// PORTS
//  clk        in   1                   clock; all state updates on posedge
//  rst        in   1                   synchronous reset, active-low
//  rd_addr    in   READ_PORTS*AW       read addresses; port p uses bits [p*AW +: AW]
//  rd_data    out  READ_PORTS*WORD_LEN read data; port p uses bits [p*WORD_LEN +: WORD_LEN]
//  wr_en      in   2                   per-port write enables
//  wr_addr    in   2*AW                write addresses; port w uses bits [w*AW +: AW]
//  wr_data    in   2*WORD_LEN          write data; port w uses bits [w*WORD_LEN +: WORD_LEN]
//  wr_ready   out  1                   1 = writes are accepted this cycle (equals !clr_busy)
//  clr_start  in   1                   request bulk clear; sampled only in IDLE
//  clr_busy   out  1                   clear sweep in progress
//  clr_done   out  1                   one-cycle pulse after the last register is cleared
// BEHAVIOUR
//  Reset (rst==0 at posedge)
//   - Every register loads its RESET_MODE value.
//   - FSM goes to IDLE; clear index = 0; clr_busy = 0; clr_done = 0.
//   - Reset overrides everything, including an in-progress sweep, which is aborted with no done pulse.
//  Reads (combinational, zero latency)
//   - rd_data[p] = reg[rd_addr[p]].
//   - Address >= WORD_COUNT returns 0.
//   - BYPASS=1 and wr_ready=1: if a valid write this cycle targets the same address, return that write data.
//   - Bypass follows the same port-1 priority as the writes.
//  Writes (posedge, only when wr_ready=1)
//   - Each port with wr_en=1 and address < WORD_COUNT updates its register.
//   - Out-of-range addresses are silently dropped.
//   - Both ports on the same address: port 1 wins; port 0's data is discarded.
//  Clear FSM: states IDLE and CLEAR; N = WORD_COUNT
//   - IDLE: clr_start=1 at edge e0 -> CLEAR with index = 0.
//   - A write presented in the same cycle as clr_start is still performed at e0.
//   - CLEAR: at edges e1..eN, reg[index] <= 0 and index increments.
//   - At eN (index==N-1): go to IDLE, index <= 0, clr_done <= 1.
//   - clr_busy = (state==CLEAR): high for exactly N cycles.
//   - clr_done is high for the single cycle after eN and is cleared at eN+1.
//   - While busy: wr_ready=0, writes are ignored, and clr_start is ignored (no re-trigger, no queueing).
//   - Reads during a sweep return current contents: already-swept registers read 0, the rest keep old values.
//   - clr_start held high through a sweep starts a new sweep at the first IDLE edge after done (back-to-back allowed).
// TESTING
//  1 Reset: rst=0 for 1 edge, RESET_MODE=1 -> reg[i]==i for all i.
//    Outputs clr_busy=0, clr_done=0, wr_ready=1.
//  2 Dual write, same address: wr_en=2'b11, both addresses = 5, data 0xAAAA_0000 / 0x5555_1111.
//    Next cycle reg5 = 0x5555_1111; bypass read in the write cycle also returns 0x5555_1111.
//  3 Bypass/range: BYPASS=1, write 0xDEAD_BEEF to r3 with rd_addr[0]=3 -> same-cycle rd_data[0]=0xDEAD_BEEF.
//    With BYPASS=0 -> old value 3.
//    Read of address 15 returns 0; a write to address 15 changes nothing.
//  4 Clear sweep: pulse clr_start -> clr_busy high for 15 cycles, then clr_done high for 1 cycle.
//    All registers read 0 afterwards; a write attempted mid-sweep is lost (wr_ready=0).
//  5 Abort: rst=0 at cycle 7 of a sweep -> busy drops, no clr_done, reg[i]==i for all i.
//  6 Back-to-back: clr_start held high -> second sweep begins at the edge after done.
//    clr_done pulses twice, 16 cycles apart.

Source files
------------

// File: rtl/register_file_mp_if.sv
// Bus bundle for register_file_mp: read ports, two write ports and the clear handshake.
// The slave modport is the register file; the master modport is decode/writeback/control.
interface register_file_mp_if #(
  parameter int WORD_LEN   = 32,
  parameter int WORD_COUNT = 15,
  parameter int READ_PORTS = 3
);
  localparam int AW = $clog2(WORD_COUNT);

  logic [READ_PORTS*AW-1:0]       rd_addr;
  logic [READ_PORTS*WORD_LEN-1:0] rd_data;
  logic [1:0]                     wr_en;
  logic [2*AW-1:0]                wr_addr;
  logic [2*WORD_LEN-1:0]          wr_data;
  logic                           wr_ready;
  logic                           clr_start;
  logic                           clr_busy;
  logic                           clr_done;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, clr_start,
    input  rd_data, wr_ready, clr_busy, clr_done
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, clr_start,
    output rd_data, wr_ready, clr_busy, clr_done
  );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port register file: combinational reads with optional write bypass, two prioritised
// write ports (port 1 wins) and a one-register-per-cycle bulk-clear sweep.
module register_file_mp #(
  parameter int WORD_LEN   = 32,
  parameter int WORD_COUNT = 15,
  parameter int READ_PORTS = 3,
  parameter bit BYPASS     = 1'b1,
  parameter bit RESET_MODE = 1'b1
) (
  input logic clk,
  input logic rst,
  register_file_mp_if.slave bus
);
  localparam int AW = $clog2(WORD_COUNT);
  localparam logic [AW:0]   NUM_WORDS = (AW+1)'(WORD_COUNT);
  localparam logic [AW-1:0] LAST_IDX  = AW'(WORD_COUNT - 1);

  typedef enum logic {IDLE, CLEAR} clrState_t;

  clrState_t state, nextState;
  logic [AW-1:0]       clrIdx;
  logic                clrDone;
  logic                clrBusy;
  logic                wrReady;
  logic [WORD_LEN-1:0] regs [WORD_COUNT];

  logic [AW-1:0]       wrAddr [2];
  logic [WORD_LEN-1:0] wrData [2];
  logic [1:0]          wrValid;
  logic [AW-1:0]       rdAddr [READ_PORTS];

  function automatic logic inRange(input logic [AW-1:0] addr);
    return {1'b0, addr} < NUM_WORDS;
  endfunction

  // Clear FSM: state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  // Clear FSM: next state; clr_start is only looked at from IDLE
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    nextState = state;
    case (state)
      IDLE:    if (bus.clr_start) nextState = CLEAR;
      CLEAR:   if (clrIdx == LAST_IDX) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Clear FSM: outputs
  always_comb begin
    clrBusy = (state == CLEAR);
    wrReady = !clrBusy;
  end

  assign bus.clr_busy = clrBusy;
  assign bus.wr_ready = wrReady;
  assign bus.clr_done = clrDone;

  always_comb begin
    for (int w = 0; w < 2; w++) begin
      wrAddr[w]  = bus.wr_addr[w*AW +: AW];
      wrData[w]  = bus.wr_data[w*WORD_LEN +: WORD_LEN];
      wrValid[w] = bus.wr_en[w] && inRange(wrAddr[w]) && wrReady;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      clrIdx  <= '0;
      clrDone <= 1'b0;
      // NOTE: the file is built from flops, not a RAM macro, so every entry can take its reset value.
      for (int i = 0; i < WORD_COUNT; i++)
        regs[i] <= RESET_MODE ? WORD_LEN'(i) : '0;
    end else begin
      clrDone <= 1'b0;
      if (state == CLEAR) begin
        regs[clrIdx] <= '0;
        if (clrIdx == LAST_IDX) begin
          clrIdx  <= '0;
          clrDone <= 1'b1;
        end else begin
          clrIdx <= clrIdx + AW'(1);
        end
      end else begin
        // NOTE: non-blocking updates to one entry resolve to the last one issued, so port 1 wins.
        for (int w = 0; w < 2; w++)
          if (wrValid[w]) regs[wrAddr[w]] <= wrData[w];
      end
    end
  end

  // Reads: stored value, then bypass in the same port order as the writes
  always_comb begin
    bus.rd_data = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      rdAddr[p] = bus.rd_addr[p*AW +: AW];
      if (inRange(rdAddr[p]))
        bus.rd_data[p*WORD_LEN +: WORD_LEN] = regs[rdAddr[p]];
      if (BYPASS)
        for (int w = 0; w < 2; w++)
          if (wrValid[w] && wrAddr[w] == rdAddr[p])
            bus.rd_data[p*WORD_LEN +: WORD_LEN] = wrData[w];
    end
  end
endmodule
